flash_prog_sequencer: RTL and testbench
=======================================

Name: flash_prog_sequencer

Overview:
- Sequences one DIP32 parallel-flash program operation on the DUT bus: a JEDEC unlock/command prefix of up to 6 (addr,data) writes, then a payload burst of up to 128 bytes to consecutive addresses.
- Completion is detected in hardware by DQ6 toggle polling, replacing the fixed software delay.
- Sits between the microcontroller register file (which holds the JEDEC and write buffers) and the ZIF pin drivers.
- Owns #CE/#OE/#WE, the address bus and DQ drive while busy.

Parameters:
- ADDR_W, 17, DUT address width.
- JEDEC_DEPTH, 6, max JEDEC prefix entries.
- BUF_DEPTH, 128, max payload bytes.
- WE_PULSE, 24, #WE low time in osc cycles (1us @24MHz).
- WE_HOLD, 24, #WE high time after each pulse.
- OE_CYCLES, 4, #OE low time per poll read before sampling.
- POLL_TIMEOUT, 240000, max osc cycles spent polling (10ms).

Ports:
- osc  in  1  24MHz clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse.
- jedec_count  in  3  prefix entry count (0..6).
- write_count  in  8  payload byte count (0..128).
- start_addr  in  ADDR_W  first payload address.
- jedec_idx  out  3  prefix buffer read index.
- jedec_addr  in  ADDR_W  prefix address at jedec_idx (combinational read).
- jedec_data  in  8  prefix data at jedec_idx.
- buf_idx  out  7  payload buffer read index.
- buf_data  in  8  payload byte at buf_idx (combinational read).
- dut_din  in  8  DQ7..0 sampled from ZIF.
- dut_addr  out  ADDR_W  DUT address.
- dut_dout  out  8  DQ value to drive.
- dut_drive  out  1  1 = FPGA drives DQ.
- dut_ce_n, dut_oe_n, dut_we_n  out  1 each  DUT strobes.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on successful completion.
- timeout_err  out  1  sticky; cleared by next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE. Outputs: ce_n=1, oe_n=1, we_n=1, dut_drive=0, busy=0, done=0, timeout_err=0, dut_addr=0, dut_dout=0, jedec_idx=0, buf_idx=0. A reset mid-pulse releases #WE in the same cycle rst_n falls.
- Accepting start:
  - start is accepted only in IDLE. The cycle after acceptance, busy=1, timeout_err=0, ce_n=0.
  - start while busy is ignored; it is not queued.
  - jedec_count and write_count are latched on acceptance. Values >6 clamp to 6; values >128 clamp to 128.
- States:
  - IDLE.
  - J_SETUP (1 cycle): dut_addr=jedec_addr, dut_dout=jedec_data, dut_drive=1.
  - J_WE: we_n=0 for WE_PULSE cycles.
  - J_HOLD: we_n=1 for WE_HOLD cycles, then jedec_idx+1. Loops to J_SETUP while idx<count, else goes to P_SETUP.
  - P_SETUP (1 cycle): dut_addr=start_addr+buf_idx (mod 2^ADDR_W), dut_dout=buf_data.
  - P_WE: we_n=0 for WE_PULSE cycles.
  - P_HOLD: we_n=1 for WE_HOLD cycles, then buf_idx+1. Loops to P_SETUP while idx<count, else goes to POLL.
  - POLL: dut_drive=0, dut_addr held at the last written address. oe_n=0 for OE_CYCLES cycles, sample DQ6 on the last low cycle, then oe_n=1 for 1 cycle. Repeat.
  - DONE (1 cycle): done=1, ce_n=1, busy=0 the following cycle, indices reset to 0, return to IDLE.
  - ERR (1 cycle): timeout_err=1, ce_n=1, return to IDLE.
- jedec_count=0: go straight to P_SETUP.
- write_count=0: skip payload and go straight to POLL.
- Both counts 0: DONE without any #WE pulse or poll.
- Toggle rule: completion when two consecutive DQ6 samples are equal. The first sample only primes the comparison.
- dut_drive falls the cycle before oe_n can go low; #OE and dut_drive are never simultaneously active.
- Timeout: a counter starts at POLL entry, incrementing every cycle. Reaching POLL_TIMEOUT→ERR, which takes precedence over a same-cycle equal-sample match.
- Address arithmetic wraps at 2^ADDR_W: 0x1FFFF+1 → 0x00000.
- Outside IDLE, only rst_n affects the sequence; start and count changes are ignored.

Decomposition:
- Package flash_seq_pkg:
  - state enum (IDLE, J_SETUP, J_WE, J_HOLD, P_SETUP, P_WE, P_HOLD, POLL, DONE, ERR);
  - default timing constants;
  - JEDEC_DEPTH/BUF_DEPTH defaults.
- Sub-module flash_seq_timer: loadable down-counter with zero flag. It is shared by the WE, hold and OE phases; the top-level FSM keeps the separate timeout counter.

Test Plan:
- Prefix (0x5555,AA),(0x2AAA,55),(0x5555,A0), payload 2 bytes 0x12,0x34 at 0x01000; DUT model toggles DQ6 for 3 reads → 5 #WE pulses, each exactly 24 cycles low. Addresses 5555,2AAA,5555,1000,1001 with the matching data. done pulses once; timeout_err=0.
- jedec_count=0, write_count=0 → no #WE edge; done one cycle after the first ce_n=0 cycle; busy high exactly 2 cycles.
- start_addr=0x1FFFF, 2 bytes → second write at 0x00000.
- DUT model toggles DQ6 forever with POLL_TIMEOUT=100 → timeout_err=1, no done, ce_n=1, IDLE. The next start clears timeout_err.
- start pulsed again during J_WE → ignored: pulse count unchanged, single done.
- rst_n asserted at cycle 10 of a P_WE pulse → we_n=1, dut_drive=0 immediately. After release, a fresh start runs the full sequence from jedec_idx=0.

Source files
------------

// File: rtl/flash_seq_pkg.sv
// Shared types and default timing for the parallel-flash program sequencer.
// Pure declarations: no latency or flow control of its own.
package flash_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, J_SETUP, J_WE, J_HOLD, P_SETUP, P_WE, P_HOLD, POLL, DONE, ERR
  } state_e;

  localparam int DEF_ADDR_W       = 17;
  localparam int DEF_JEDEC_DEPTH  = 6;
  localparam int DEF_BUF_DEPTH    = 128;
  localparam int DEF_WE_PULSE     = 24;
  localparam int DEF_WE_HOLD      = 24;
  localparam int DEF_OE_CYCLES    = 4;
  localparam int DEF_POLL_TIMEOUT = 240000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// Loadable down-counter with a zero flag, shared by the #WE, hold and #OE phases.
// Load takes effect next cycle; it then counts to zero and stays there until reloaded.
module flash_seq_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flash_prog_sequencer.sv
// Drives one JEDEC-prefixed program burst onto a DIP32 flash, then DQ6-toggle polls for completion.
// Busy from the cycle after start until one cycle after done/error; start is ignored while busy.
module flash_prog_sequencer
  import flash_seq_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int JEDEC_DEPTH  = DEF_JEDEC_DEPTH,
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
  parameter int WE_PULSE     = DEF_WE_PULSE,
  parameter int WE_HOLD      = DEF_WE_HOLD,
  parameter int OE_CYCLES    = DEF_OE_CYCLES,
  parameter int POLL_TIMEOUT = DEF_POLL_TIMEOUT
) (
  input  logic              osc_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [2:0]        jedec_count_i,
  input  logic [7:0]        write_count_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic [2:0]        jedec_idx_o,
  input  logic [ADDR_W-1:0] jedec_addr_i,
  input  logic [7:0]        jedec_data_i,
  output logic [6:0]        buf_idx_o,
  input  logic [7:0]        buf_data_i,
  input  logic [7:0]        dut_din_i,
  output logic [ADDR_W-1:0] dut_addr_o,
  output logic [7:0]        dut_dout_o,
  output logic              dut_drive_o,
  output logic              dut_ce_n_o,
  output logic              dut_oe_n_o,
  output logic              dut_we_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_err_o
);

  localparam int TMR_W = cnt_width(max3(WE_PULSE, WE_HOLD, OE_CYCLES));
  localparam int TO_W  = cnt_width(POLL_TIMEOUT);

  localparam logic [2:0]       J_MAX   = 3'(JEDEC_DEPTH);
  localparam logic [7:0]       W_MAX   = 8'(BUF_DEPTH);
  localparam logic [TMR_W-1:0] T_WE    = TMR_W'(WE_PULSE - 1);
  localparam logic [TMR_W-1:0] T_HOLD  = TMR_W'(WE_HOLD - 1);
  localparam logic [TMR_W-1:0] T_OE    = TMR_W'(OE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(POLL_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        jcnt_q, jcnt_d, jidx_q, jidx_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [6:0]        bidx_q, bidx_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, pay_addr;
  logic [7:0]        dout_q, dout_d;
  logic              poll_oe_q, poll_oe_d, primed_q, primed_d, dq6_q, dq6_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              drive_q, drive_d, busy_q, busy_d, done_q, done_d;
  logic              tmr_load, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;
  logic              unused_din;

  assign unused_din = ^{dut_din_i[7], dut_din_i[5:0]};
  assign pay_addr   = base_q + ADDR_W'(bidx_q);

  flash_seq_timer #(.W(TMR_W)) u_timer (
    .clk_i      (osc_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    jcnt_d    = jcnt_q;
    wcnt_d    = wcnt_q;
    jidx_d    = jidx_q;
    bidx_d    = bidx_q;
    base_d    = base_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    dq6_d     = dq6_q;
    err_d     = err_q;
    poll_oe_d = 1'b0;
    primed_d  = 1'b0;
    to_cnt_d  = '0;
    tmr_load  = 1'b0;
    tmr_val   = T_WE;

    case (state_q)
      IDLE: if (start_i) begin
        err_d  = 1'b0;
        jcnt_d = (jedec_count_i > J_MAX) ? J_MAX : jedec_count_i;
        wcnt_d = (write_count_i > W_MAX) ? W_MAX : write_count_i;
        base_d = start_addr_i;
        jidx_d = '0;
        bidx_d = '0;
        if (jcnt_d != '0)      state_d = J_SETUP;
        else if (wcnt_d != '0) state_d = P_SETUP;
        else                   state_d = POLL;
      end
      J_SETUP: begin
        addr_d   = jedec_addr_i;
        dout_d   = jedec_data_i;
        state_d  = J_WE;
        tmr_load = 1'b1;
        tmr_val  = T_WE;
      end
      J_WE: if (tmr_zero) begin
        state_d  = J_HOLD;
        tmr_load = 1'b1;
        tmr_val  = T_HOLD;
      end
      J_HOLD: if (tmr_zero) begin
        jidx_d = jidx_q + 3'd1;
        if (jidx_q + 3'd1 < jcnt_q) state_d = J_SETUP;
        else if (wcnt_q != '0)      state_d = P_SETUP;
        else                        state_d = POLL;
      end
      P_SETUP: begin
        addr_d   = pay_addr;
        dout_d   = buf_data_i;
        state_d  = P_WE;
        tmr_load = 1'b1;
        tmr_val  = T_WE;
      end
      P_WE: if (tmr_zero) begin
        state_d  = P_HOLD;
        tmr_load = 1'b1;
        tmr_val  = T_HOLD;
      end
      P_HOLD: if (tmr_zero) begin
        bidx_d = bidx_q + 7'd1;
        if ({1'b0, bidx_q} + 8'd1 < wcnt_q) state_d = P_SETUP;
        else                                state_d = POLL;
      end
      POLL: begin
        // Entry cycle keeps #OE high so DQ is released before the first read.
        to_cnt_d  = to_cnt_q + 1'b1;
        poll_oe_d = poll_oe_q;
        primed_d  = primed_q;
        if (to_cnt_q >= TO_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (jcnt_q == '0 && wcnt_q == '0) begin
          state_d = DONE;
        end else if (!poll_oe_q) begin
          poll_oe_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = T_OE;
        end else if (tmr_zero) begin
          poll_oe_d = 1'b0;
          primed_d  = 1'b1;
          dq6_d     = dut_din_i[6];
          if (primed_q && (dut_din_i[6] == dq6_q)) state_d = DONE;
        end
      end
      DONE, ERR: begin
        jidx_d  = '0;
        bidx_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so the pins never glitch.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    ce_n_d  = !(state_d inside {J_SETUP, J_WE, J_HOLD, P_SETUP, P_WE, P_HOLD, POLL});
    we_n_d  = !(state_d inside {J_WE, P_WE});
    drive_d = (state_d inside {J_SETUP, J_WE, J_HOLD, P_SETUP, P_WE, P_HOLD});
    oe_n_d  = !((state_d == POLL) && poll_oe_d);
  end

  always_ff @(posedge osc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      jcnt_q    <= '0;
      wcnt_q    <= '0;
      jidx_q    <= '0;
      bidx_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      poll_oe_q <= 1'b0;
      primed_q  <= 1'b0;
      dq6_q     <= 1'b0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      jcnt_q    <= jcnt_d;
      wcnt_q    <= wcnt_d;
      jidx_q    <= jidx_d;
      bidx_q    <= bidx_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      poll_oe_q <= poll_oe_d;
      primed_q  <= primed_d;
      dq6_q     <= dq6_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Setup cycles present the combinational buffer read directly; it is held from then on.
  assign dut_addr_o    = (state_q == J_SETUP) ? jedec_addr_i :
                         (state_q == P_SETUP) ? pay_addr     : addr_q;
  assign dut_dout_o    = (state_q == J_SETUP) ? jedec_data_i :
                         (state_q == P_SETUP) ? buf_data_i   : dout_q;
  assign jedec_idx_o   = jidx_q;
  assign buf_idx_o     = bidx_q;
  assign dut_drive_o   = drive_q;
  assign dut_ce_n_o    = ce_n_q;
  assign dut_oe_n_o    = oe_n_q;
  assign dut_we_n_o    = we_n_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_flash_prog_sequencer.sv
// Scoreboard bench: expected flash writes are queued at start and popped on each #WE fall.
// A small flash model toggles DQ6 on each read for a programmable number of reads.
module tb_flash_prog_sequencer;

  localparam int AW = 17;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic          osc = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [2:0]    jedec_count = '0;
  logic [7:0]    write_count = '0;
  logic [AW-1:0] start_addr = '0;
  logic [2:0]    jedec_idx;
  logic [AW-1:0] jedec_addr;
  logic [7:0]    jedec_data;
  logic [6:0]    buf_idx;
  logic [7:0]    buf_data;
  logic [7:0]    dut_din;
  logic [AW-1:0] dut_addr;
  logic [7:0]    dut_dout;
  logic          dut_drive, dut_ce_n, dut_oe_n, dut_we_n, busy, done, timeout_err;

  logic [AW-1:0] jed_addr [8];
  logic [7:0]    jed_data [8];
  logic [7:0]    buf_mem  [128];

  assign jedec_addr = jed_addr[jedec_idx];
  assign jedec_data = jed_data[jedec_idx];
  assign buf_data   = buf_mem[buf_idx];

  logic dq6_m = 1'b0;
  int   toggles_left = 0;
  bit   toggle_forever = 1'b0;
  assign dut_din = {1'b0, dq6_m, 6'b0};

  always #20 osc = ~osc;

  flash_prog_sequencer #(.POLL_TIMEOUT(100)) dut (
    .osc_i(osc), .rst_n_i(rst_n), .start_i(start),
    .jedec_count_i(jedec_count), .write_count_i(write_count), .start_addr_i(start_addr),
    .jedec_idx_o(jedec_idx), .jedec_addr_i(jedec_addr), .jedec_data_i(jedec_data),
    .buf_idx_o(buf_idx), .buf_data_i(buf_data), .dut_din_i(dut_din),
    .dut_addr_o(dut_addr), .dut_dout_o(dut_dout), .dut_drive_o(dut_drive),
    .dut_ce_n_o(dut_ce_n), .dut_oe_n_o(dut_oe_n), .dut_we_n_o(dut_we_n),
    .busy_o(busy), .done_o(done), .timeout_err_o(timeout_err)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash model: each read (falling #OE) flips DQ6 while the part is "busy".
  always @(negedge dut_oe_n) begin
    if (toggle_forever || toggles_left > 0) begin
      dq6_m = ~dq6_m;
      if (toggles_left > 0) toggles_left--;
    end
  end

  wr_t exp_q[$];
  wr_t e;
  logic prev_we = 1'b1, prev_oe = 1'b1;
  bit   skip_width = 1'b0;
  int   lowcnt = 0, pulse_cnt = 0, done_cnt = 0, oe_reads = 0, viol = 0;
  int   busy_cnt = 0, cyc = 0, first_ce = -1, done_cyc = -1;

  always @(negedge osc) begin
    cyc++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!dut_ce_n && first_ce < 0) first_ce = cyc;
    if (!dut_oe_n && dut_drive) viol++;
    if (prev_oe && !dut_oe_n) oe_reads++;
    if (prev_we && !dut_we_n) begin
      pulse_cnt++;
      lowcnt = 1;
      if (exp_q.size() == 0) check("we_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("we_addr", 32'(dut_addr), 32'(e.a));
        check("we_data", 32'(dut_dout), 32'(e.d));
        check("we_drive", 32'(dut_drive), 1);
      end
    end else if (!dut_we_n) lowcnt++;
    if (!prev_we && dut_we_n) begin
      if (skip_width) skip_width = 1'b0;
      else check("we_width", lowcnt, 24);
    end
    prev_we = dut_we_n;
    prev_oe = dut_oe_n;
  end

  int p0, d0, r0;

  task automatic issue_op(input logic [2:0] jc, input logic [7:0] wc, input logic [AW-1:0] sa,
                          input int tog, input bit forever_t);
    int nj, nw;
    jedec_count = jc; write_count = wc; start_addr = sa;
    toggles_left = tog; toggle_forever = forever_t;
    nj = (jc > 3'd6) ? 6 : int'(jc);
    nw = (wc > 8'd128) ? 128 : int'(wc);
    for (int i = 0; i < nj; i++) exp_q.push_back('{a: jed_addr[i], d: jed_data[i]});
    for (int i = 0; i < nw; i++) exp_q.push_back('{a: AW'(sa + AW'(i)), d: buf_mem[i]});
    busy_cnt = 0; first_ce = -1; done_cyc = -1;
    p0 = pulse_cnt; d0 = done_cnt; r0 = oe_reads;
    @(posedge osc); #1 start = 1'b1;
    @(posedge osc); #1 start = 1'b0;
    check("acc_busy", 32'(busy), 1);
    check("acc_ce_n", 32'(dut_ce_n), 0);
    check("acc_err", 32'(timeout_err), 0);
  endtask

  task automatic run_op(input logic [2:0] jc, input logic [7:0] wc, input logic [AW-1:0] sa,
                        input int tog, input bit forever_t, input bit restart);
    int n;
    bit pulsed;
    issue_op(jc, wc, sa, tog, forever_t);
    n = 0; pulsed = 1'b0;
    while (busy && n < 4000) begin
      @(posedge osc); #1;
      n++;
      if (restart && !pulsed && !dut_we_n) begin start = 1'b1; pulsed = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    check("op_ends", 32'(busy), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin jed_addr[i] = AW'(i * 17'h111); jed_data[i] = 8'(i + 8'hC0); end
    for (int i = 0; i < 128; i++) buf_mem[i] = 8'(i * 7 + 3);
    jed_addr[0] = 17'h05555; jed_data[0] = 8'hAA;
    jed_addr[1] = 17'h02AAA; jed_data[1] = 8'h55;
    jed_addr[2] = 17'h05555; jed_data[2] = 8'hA0;
    buf_mem[0] = 8'h12; buf_mem[1] = 8'h34;

    #5 rst_n = 1'b0;
    repeat (3) @(posedge osc);
    #1;
    check("rst_ce_n",  32'(dut_ce_n), 1);
    check("rst_oe_n",  32'(dut_oe_n), 1);
    check("rst_we_n",  32'(dut_we_n), 1);
    check("rst_drive", 32'(dut_drive), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_err",   32'(timeout_err), 0);
    check("rst_addr",  32'(dut_addr), 0);
    check("rst_dout",  32'(dut_dout), 0);
    check("rst_jidx",  32'(jedec_idx), 0);
    check("rst_bidx",  32'(buf_idx), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge osc);

    // JEDEC prefix + 2-byte payload, 3 toggling reads before settle.
    run_op(3'd3, 8'd2, 17'h01000, 3, 1'b0, 1'b0);
    check("t1_pulses", pulse_cnt - p0, 5);
    check("t1_done",   done_cnt - d0, 1);
    check("t1_reads",  oe_reads - r0, 4);
    check("t1_err",    32'(timeout_err), 0);

    // Nothing to do: done right after the first #CE cycle.
    run_op(3'd0, 8'd0, 17'h00000, 0, 1'b0, 1'b0);
    check("t2_pulses", pulse_cnt - p0, 0);
    check("t2_reads",  oe_reads - r0, 0);
    check("t2_busy",   busy_cnt, 2);
    check("t2_done_at", done_cyc - first_ce, 1);
    check("t2_done",   done_cnt - d0, 1);

    // Address wrap at the top of the part.
    run_op(3'd0, 8'd2, 17'h1FFFF, 0, 1'b0, 1'b0);
    check("t3_pulses", pulse_cnt - p0, 2);
    check("t3_done",   done_cnt - d0, 1);

    // DQ6 never settles: 100 poll cycles hold exactly 20 reads, then error.
    run_op(3'd1, 8'd1, 17'h00100, 0, 1'b1, 1'b0);
    toggle_forever = 1'b0;
    check("t4_err",    32'(timeout_err), 1);
    check("t4_done",   done_cnt - d0, 0);
    check("t4_ce_n",   32'(dut_ce_n), 1);
    check("t4_reads",  oe_reads - r0, 20);
    run_op(3'd1, 8'd1, 17'h00100, 1, 1'b0, 1'b0);
    check("t4b_err",   32'(timeout_err), 0);
    check("t4b_done",  done_cnt - d0, 1);

    // Second start during a #WE pulse must be dropped; counts above max clamp.
    run_op(3'd7, 8'd0, 17'h02000, 2, 1'b0, 1'b1);
    check("t5_pulses", pulse_cnt - p0, 6);
    check("t5_done",   done_cnt - d0, 1);

    // Reset ten cycles into the first payload pulse.
    issue_op(3'd1, 8'd2, 17'h03000, 1, 1'b0);
    n = 0;
    while (!(pulse_cnt - p0 == 2 && lowcnt == 10 && !dut_we_n) && n < 2000) begin
      @(negedge osc); #1;
      n++;
    end
    check("t6_reach", 32'(n < 2000), 1);
    rst_n = 1'b0;
    #1;
    check("t6_we_n",  32'(dut_we_n), 1);
    check("t6_drive", 32'(dut_drive), 0);
    check("t6_busy",  32'(busy), 0);
    exp_q.delete();
    skip_width = 1'b1;
    repeat (2) @(posedge osc);
    #1 rst_n = 1'b1;
    check("t6_jidx",  32'(jedec_idx), 0);
    run_op(3'd3, 8'd2, 17'h01000, 3, 1'b0, 1'b0);
    check("t6_pulses", pulse_cnt - p0, 5);
    check("t6_done",   done_cnt - d0, 1);

    check("queue_empty", exp_q.size(), 0);
    check("oe_drive_overlap", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
